// File: rtl/timer_array_pkg.sv
// rtl/timer_array_pkg.sv - shared channel state encodings for timer_array
package timer_array_pkg;

  localparam int TIMR_STATE_W = 2;

  localparam logic [TIMR_STATE_W-1:0] TIMR_IDLE_S  = 2'd0;
  localparam logic [TIMR_STATE_W-1:0] TIMR_COUNT_S = 2'd1;

endpackage

// File: rtl/timer_array_channel.sv
// rtl/timer_array_channel.sv - one timer channel: FSM, counter, latched limit and mode
module timer_channel
  import timer_array_pkg::*;
#(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic             pulse,
  output logic             busy
);

  logic [TIMR_STATE_W-1:0] state;
  logic [WIDTH-1:0]        cnt;
  logic [WIDTH-1:0]        lim_q;
  logic                    per_q;

  // Priority within a cycle: clr > stop > start > terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TIMR_IDLE_S;
      cnt   <= '0;
      lim_q <= '0;
      per_q <= 1'b0;
      pulse <= 1'b0;
    end else if (clr) begin
      state <= TIMR_IDLE_S;
      cnt   <= '0;
      lim_q <= '0;
      per_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        TIMR_IDLE_S: begin
          if (start && !stop) begin
            lim_q <= limit;
            per_q <= periodic;
            cnt   <= '0;
            state <= TIMR_COUNT_S;
          end
        end
        TIMR_COUNT_S: begin
          if (stop) begin
            cnt   <= '0;
            state <= TIMR_IDLE_S;
          end else if (start) begin
            lim_q <= limit;
            per_q <= periodic;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == lim_q) begin
              pulse <= 1'b1;
              cnt   <= '0;
              if (!per_q) state <= TIMR_IDLE_S;
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= TIMR_IDLE_S;
        end
      endcase
    end
  end

  assign busy = (state == TIMR_COUNT_S);

endmodule

// File: rtl/timer_array.sv
// rtl/timer_array.sv - multi-channel interval timer sharing one free-running prescaler
module timer_array
  import timer_array_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 21,
  parameter int PRESCALE_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLR,
  input  logic [PRESCALE_W-1:0]   PRESCALE,
  input  logic [NUM_CH-1:0]       START,
  input  logic [NUM_CH-1:0]       STOP,
  input  logic [NUM_CH-1:0]       PERIODIC,
  input  logic [NUM_CH*WIDTH-1:0] LIMIT,
  output logic [NUM_CH-1:0]       PULSE,
  output logic [NUM_CH-1:0]       BUSY
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;

  // >= rather than == so lowering PRESCALE mid-run never forces a wrap.
  assign tick = (pcnt >= PRESCALE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt <= '0;
    end else if (CLR || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .clr      (CLR),
      .tick     (tick),
      .start    (START[i]),
      .stop     (STOP[i]),
      .periodic (PERIODIC[i]),
      .limit    (LIMIT[i*WIDTH +: WIDTH]),
      .pulse    (PULSE[i]),
      .busy     (BUSY[i])
    );
  end

endmodule
